// File: rtl/cmi_rx_frame_ctrl.sv
// CMI receive frame controller: checks CMI code rules, hunts/verifies/locks onto the
// sync word and assembles payload bits into bytes while locked.
module cmi_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_WORD   = 8'b1110_0100,
  parameter int         FRAME_BYTES = 4,
  parameter int         CONFIRM     = 2,
  parameter int         MISS_LIMIT  = 2,
  parameter int         VIOL_LIMIT  = 3
) (
  input  logic        clk_sig,
  input  logic        reset_sig,
  input  logic        sym_valid,
  input  logic [1:0]  encode_sig,
  input  logic        decode_sig,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        viol_pulse,
  output logic [15:0] viol_cnt
);
  localparam int PAY_BITS   = FRAME_BYTES * 8;
  localparam int FRAME_BITS = PAY_BITS + 8;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int GOOD_W     = $clog2(CONFIRM + 1);
  localparam int MISS_W     = $clog2(MISS_LIMIT + 1);
  localparam int VIOL_W     = $clog2(VIOL_LIMIT + 2);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCK = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                bit_valid_q;
  logic [1:0]          sym_q;
  logic                pol_q, pol_d;
  logic [7:0]          sr_q, sr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [VIOL_W-1:0]   vf_cnt_q, vf_cnt_d;
  logic [7:0]          byte_data_q, byte_data_d;
  logic                byte_valid_q, byte_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                viol_pulse_q, viol_pulse_d;
  logic [15:0]         viol_cnt_q, viol_cnt_d;

  logic       is_one, viol, sync_hit, at_sync, in_payload, byte_end;
  logic       confirm_hit, miss_out, vf_over;
  logic [7:0] sr_nxt;

  // Per-bit decode: pol_q holds sym[0] of the last '1' symbol (0 means 2'b00)
  always_comb begin
    is_one      = (sym_q == 2'b00) || (sym_q == 2'b11);
    viol        = (sym_q == 2'b10) || (is_one && (sym_q[0] == pol_q));
    sr_nxt      = {sr_q[6:0], decode_sig};
    sync_hit    = (sr_nxt == SYNC_WORD);
    at_sync     = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
    in_payload  = (int'(bit_cnt_q) < PAY_BITS);
    byte_end    = in_payload && (bit_cnt_q[2:0] == 3'b111);
    confirm_hit = (int'(good_cnt_q) + 1) >= CONFIRM;
    miss_out    = (int'(miss_cnt_q) + 1) >= MISS_LIMIT;
    vf_over     = (int'(vf_cnt_q) + int'(viol)) > VIOL_LIMIT;
  end

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) state_q <= HUNT;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bit_valid_q) begin
      case (state_q)
        HUNT:    if (sync_hit) state_d = VERIFY;
        VERIFY:  if (at_sync) state_d = !sync_hit ? HUNT : (confirm_hit ? LOCK : VERIFY);
        LOCK:    if (vf_over || (at_sync && !sync_hit && miss_out)) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    pol_d         = pol_q;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    good_cnt_d    = good_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    vf_cnt_d      = vf_cnt_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    viol_pulse_d  = 1'b0;
    viol_cnt_d    = viol_cnt_q;
    if (bit_valid_q) begin
      viol_pulse_d = viol;
      if (viol && (viol_cnt_q != 16'hFFFF)) viol_cnt_d = viol_cnt_q + 16'd1;
      if (is_one) pol_d = sym_q[0];
      sr_d      = sr_nxt;
      bit_cnt_d = at_sync ? '0 : bit_cnt_q + CNT_W'(1);
      case (state_q)
        HUNT: begin
          bit_cnt_d  = '0;
          good_cnt_d = '0;
        end
        VERIFY: begin
          if (at_sync && sync_hit) begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
            miss_cnt_d = '0;
            vf_cnt_d   = '0;
          end
        end
        LOCK: begin
          // Too many violations drops lock immediately; any partial byte is lost
          if (!vf_over) begin
            vf_cnt_d = at_sync ? '0 : vf_cnt_q + VIOL_W'(viol);
            if (at_sync) miss_cnt_d = sync_hit ? '0 : miss_cnt_q + MISS_W'(1);
            if (byte_end) begin
              byte_data_d   = sr_nxt;
              byte_valid_d  = 1'b1;
              frame_start_d = (bit_cnt_q == CNT_W'(7));
            end
          end
        end
        default: bit_cnt_d = '0;
      endcase
    end
  end

  // Stage 1: symbol register aligns the symbol with the decoder's output bit
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      bit_valid_q   <= 1'b0;
      sym_q         <= 2'b00;
      pol_q         <= 1'b0;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      good_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      vf_cnt_q      <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      viol_pulse_q  <= 1'b0;
      viol_cnt_q    <= '0;
    end else begin
      bit_valid_q   <= sym_valid;
      sym_q         <= encode_sig;
      pol_q         <= pol_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      vf_cnt_q      <= vf_cnt_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      viol_pulse_q  <= viol_pulse_d;
      viol_cnt_q    <= viol_cnt_d;
    end
  end

  always_comb begin
    locked      = (state_q == LOCK);
    byte_data   = byte_data_q;
    byte_valid  = byte_valid_q;
    frame_start = frame_start_q;
    viol_pulse  = viol_pulse_q;
    viol_cnt    = viol_cnt_q;
  end

endmodule

// File: tb/tb_cmi_rx_frame_ctrl.sv
// Frame-level directed bench for cmi_rx_frame_ctrl: a CMI encoder/decoder model drives
// whole frames from a table; lock, bytes and violation counts are compared per frame.
module tb_cmi_rx_frame_ctrl;
  logic        clk_sig = 1'b0;
  logic        reset_sig = 1'b0;
  logic        sym_valid = 1'b0;
  logic [1:0]  encode_sig = 2'b01;
  logic        decode_sig = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid, frame_start, locked, viol_pulse;
  logic [15:0] viol_cnt;

  bit clk_run = 1'b1;
  int checks = 0;
  int errors = 0;

  cmi_rx_frame_ctrl dut (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .sym_valid(sym_valid),
    .encode_sig(encode_sig), .decode_sig(decode_sig), .byte_data(byte_data),
    .byte_valid(byte_valid), .frame_start(frame_start), .locked(locked),
    .viol_pulse(viol_pulse), .viol_cnt(viol_cnt)
  );

  initial forever begin
    #5;
    if (clk_run) clk_sig = ~clk_sig;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  sync;
    logic [31:0] pay;
    int          code_v;
    int          pol_v;
    bit          gap;
    bit          exp_lock;
    int          exp_bytes;
    int          exp_vcnt;
  } row_t;

  row_t rows[17];

  logic [1:0] last_one = 2'b00;
  logic       prev_bit = 1'b0;
  logic [7:0] bq[$];
  logic       fsq[$];
  logic       lkq[$];
  int         vp_seen = 0;
  int         last_vcnt = 0;

  always @(negedge clk_sig) begin
    if (reset_sig) begin
      if (byte_valid) begin
        bq.push_back(byte_data);
        fsq.push_back(frame_start);
        lkq.push_back(locked);
      end
      if (viol_pulse) vp_seen++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // decode_sig carries the bit of the symbol latched at the previous edge
  task automatic drive(input logic v, input logic [1:0] s, input logic b);
    @(negedge clk_sig);
    sym_valid  = v;
    encode_sig = s;
    decode_sig = prev_bit;
    if (v) prev_bit = b;
  endtask

  task automatic send_bit(input logic b);
    logic [1:0] s;
    if (b) begin
      s = (last_one == 2'b00) ? 2'b11 : 2'b00;
      last_one = s;
    end else begin
      s = 2'b01;
    end
    drive(1'b1, s, b);
  endtask

  task automatic idle();
    drive(1'b0, 2'b01, prev_bit);
  endtask

  task automatic apply_row(input row_t r, input int idx);
    int cl, pl, base_vp, n;
    logic b;
    logic [7:0] eb;
    bq.delete(); fsq.delete(); lkq.delete();
    base_vp = vp_seen;
    cl = r.code_v;
    pl = r.pol_v;
    for (int i = 7; i >= 0; i--) begin
      send_bit(r.sync[i]);
      if (r.gap) idle();
    end
    for (int i = 31; i >= 0; i--) begin
      b = r.pay[i];
      if (!b && cl > 0) begin
        drive(1'b1, 2'b10, 1'b0);
        cl--;
      end else if (b && pl > 0) begin
        drive(1'b1, last_one, 1'b1);
        pl--;
      end else begin
        send_bit(b);
      end
      if (r.gap) idle();
    end
    repeat (3) idle();
    chk($sformatf("row%0d locked", idx), {31'd0, locked}, {31'd0, r.exp_lock});
    chk($sformatf("row%0d viol_cnt", idx), {16'd0, viol_cnt}, r.exp_vcnt);
    chk($sformatf("row%0d viol_pulses", idx), vp_seen - base_vp, r.exp_vcnt - last_vcnt);
    chk($sformatf("row%0d byte_count", idx), bq.size(), r.exp_bytes);
    n = (bq.size() < r.exp_bytes) ? bq.size() : r.exp_bytes;
    for (int k = 0; k < n; k++) begin
      eb = r.pay[31 - 8*k -: 8];
      chk($sformatf("row%0d byte%0d data", idx, k), {24'd0, bq[k]}, {24'd0, eb});
      chk($sformatf("row%0d byte%0d frame_start", idx, k), {31'd0, fsq[k]}, (k == 0) ? 1 : 0);
      chk($sformatf("row%0d byte%0d locked", idx, k), {31'd0, lkq[k]}, 1);
    end
    last_vcnt = r.exp_vcnt;
  endtask

  initial begin
    //            sync    payload        code pol gap  lock bytes vcnt
    rows[0]  = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b0, 0, 0};
    rows[1]  = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b0, 0, 0};
    rows[2]  = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b1, 4, 0};
    rows[3]  = '{8'hE4, 32'h11223344, 0, 0, 1'b1, 1'b1, 4, 0};
    rows[4]  = '{8'hE4, 32'h11223344, 1, 0, 1'b0, 1'b1, 4, 1};
    rows[5]  = '{8'hE4, 32'h11223344, 0, 1, 1'b0, 1'b1, 4, 2};
    rows[6]  = '{8'hE5, 32'h11223344, 0, 0, 1'b0, 1'b1, 4, 2};
    rows[7]  = '{8'hE5, 32'h11223344, 0, 0, 1'b0, 1'b0, 0, 2};
    rows[8]  = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b0, 0, 2};
    rows[9]  = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b0, 0, 2};
    rows[10] = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b1, 4, 2};
    rows[11] = '{8'hE4, 32'h11223344, 4, 0, 1'b0, 1'b0, 0, 6};
    rows[12] = '{8'h00, 32'hE4000000, 0, 0, 1'b0, 1'b0, 0, 6};
    rows[13] = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b0, 0, 6};
    rows[14] = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b0, 0, 6};
    rows[15] = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b0, 0, 6};
    rows[16] = '{8'hE4, 32'h11223344, 0, 0, 1'b0, 1'b1, 4, 6};

    repeat (3) @(negedge clk_sig);
    chk("reset locked", {31'd0, locked}, 0);
    chk("reset byte_valid", {31'd0, byte_valid}, 0);
    chk("reset byte_data", {24'd0, byte_data}, 0);
    chk("reset viol_cnt", {16'd0, viol_cnt}, 0);
    chk("reset viol_pulse", {31'd0, viol_pulse}, 0);
    chk("reset frame_start", {31'd0, frame_start}, 0);
    reset_sig = 1'b1;

    for (int i = 0; i < 17; i++) apply_row(rows[i], i);

    // Reset mid-byte with the clock held low: outputs must clear without an edge
    for (int i = 7; i >= 0; i--) send_bit(rows[0].sync[i]);
    for (int i = 31; i >= 28; i--) send_bit(rows[0].pay[i]);
    clk_run = 1'b0;
    #2;
    chk("pre-reset locked", {31'd0, locked}, 1);
    chk("pre-reset viol_cnt", {16'd0, viol_cnt}, 6);
    chk("pre-reset byte_data", {24'd0, byte_data}, 32'h44);
    reset_sig = 1'b0;
    #1;
    chk("async reset locked", {31'd0, locked}, 0);
    chk("async reset viol_cnt", {16'd0, viol_cnt}, 0);
    chk("async reset byte_data", {24'd0, byte_data}, 0);
    chk("async reset byte_valid", {31'd0, byte_valid}, 0);
    chk("async reset frame_start", {31'd0, frame_start}, 0);
    chk("async reset viol_pulse", {31'd0, viol_pulse}, 0);
    chk("clock held low", {31'd0, clk_sig}, 0);
    #10;
    sym_valid = 1'b0;
    last_one  = 2'b00;
    prev_bit  = 1'b0;
    vp_seen   = 0;
    last_vcnt = 0;
    reset_sig = 1'b1;
    #2;
    clk_run = 1'b1;

    for (int i = 0; i < 3; i++) apply_row(rows[i], 100 + i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
